// File: rtl/data_mem_arb_pkg.sv
// ============================================================================
//  Module   : data_mem_arb_pkg
//  Brief    : Shared types and constants for the data memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic [1:0] MEMSRC_BYTE = 2'b00;
    localparam logic [1:0] MEMSRC_HALF = 2'b01;
    localparam logic [1:0] MEMSRC_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  memsrc;
    } req_t;

    typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_align_chk.sv
// ============================================================================
//  Module   : data_mem_align_chk
//  Brief    : Flags misaligned half/word accesses and the reserved size code.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_align_chk
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] memsrc,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (memsrc)
            MEMSRC_BYTE: misaligned = 1'b0;
            MEMSRC_HALF: misaligned = addr_lo[0];
            MEMSRC_WORD: misaligned = |addr_lo;
            default:     misaligned = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
//  Module   : data_mem_arbiter
//  Brief    : Two-port fixed-priority arbiter with starvation guard in front of
//             a single-port data memory. Alignment checking is enabled by
//             defining DATA_MEM_ARB_ALIGN_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int A_WIDTH      = 20,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req0_we,
    input  logic [2:0]  req0_memsrc,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic        req1_we,
    input  logic [2:0]  req1_memsrc,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    output logic [2:0]  mem_MemSrc,
    input  logic [31:0] mem_RD
);

    localparam logic [3:0]  c_limit     = 4'(STARVE_LIMIT);
    localparam logic [31:0] c_addr_mask = 32'((64'd1 << A_WIDTH) - 64'd1);

    arb_state_t  r_state, w_next_state;
    req_t        r_req;
    req_id_t     r_id;
    logic [3:0]  r_starve_cnt;
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp0_rdata, r_rsp1_rdata;
    logic        r_rsp_err;

    logic        w_grant0, w_grant1, w_misaligned, w_active;
    req_t        w_req0, w_req1;

    assign w_req0 = {req0_addr, req0_wdata, req0_we, req0_memsrc};
    assign w_req1 = {req1_addr, req1_wdata, req1_we, req1_memsrc};

    // The loader wins a contested cycle only once the core has starved it.
    assign w_grant0 = (r_state == IDLE) && req0_valid &&
                      (!req1_valid || (r_starve_cnt != c_limit));
    assign w_grant1 = (r_state == IDLE) && req1_valid &&
                      (!req0_valid || (r_starve_cnt == c_limit));

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
    data_mem_align_chk u_align_chk (
        .addr_lo    (r_req.addr[1:0]),
        .memsrc     (r_req.memsrc[1:0]),
        .misaligned (w_misaligned)
    );
`else
    assign w_misaligned = 1'b0;
`endif

    // Reset has priority over an in-flight access, so it gates the memory drive.
    assign w_active   = (r_state == ACCESS) && !w_misaligned && !rst;
    assign mem_A      = w_active ? (r_req.addr & c_addr_mask) : '0;
    assign mem_WD     = w_active ? r_req.wdata  : '0;
    assign mem_WE     = w_active && r_req.we;
    assign mem_MemSrc = w_active ? r_req.memsrc : '0;

    assign req0_ready = w_grant0 && !rst;
    assign req1_ready = w_grant1 && !rst;

    assign rsp0_valid = r_rsp_valid[0] && !rst;
    assign rsp1_valid = r_rsp_valid[1] && !rst;
    assign rsp0_err   = r_rsp_valid[0] && r_rsp_err && !rst;
    assign rsp1_err   = r_rsp_valid[1] && r_rsp_err && !rst;
    assign rsp0_rdata = rst ? '0 : r_rsp0_rdata;
    assign rsp1_rdata = rst ? '0 : r_rsp1_rdata;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant0 || w_grant1) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_id         <= 1'b0;
            r_starve_cnt <= '0;
            r_rsp_valid  <= '0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_rsp_valid  <= '0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
            r_rsp_err    <= 1'b0;
            if (w_grant1) begin
                r_req        <= w_req1;
                r_id         <= 1'b1;
                r_starve_cnt <= '0;
            end else if (w_grant0) begin
                r_req <= w_req0;
                r_id  <= 1'b0;
                if (!req1_valid)
                    r_starve_cnt <= '0;
                else if (r_starve_cnt != c_limit)
                    r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (r_state == ACCESS) begin
                r_rsp_valid[r_id] <= 1'b1;
                r_rsp_err         <= w_misaligned;
                if (!r_id)
                    r_rsp0_rdata <= (r_req.we || w_misaligned) ? '0 : mem_RD;
                else
                    r_rsp1_rdata <= (r_req.we || w_misaligned) ? '0 : mem_RD;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Brief    : Directed self-checking bench for data_mem_arbiter with a simple
//             byte-addressed data memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_err;
    logic        req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_err;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [2:0]  req0_memsrc, req1_memsrc, mem_MemSrc;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.A_WIDTH(20), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_we(req0_we), .req0_memsrc(req0_memsrc),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_we(req1_we), .req1_memsrc(req1_memsrc),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
        .mem_MemSrc(mem_MemSrc), .mem_RD(mem_RD)
    );

    // Little-endian byte memory; reads are combinational, stores commit at the edge.
    logic [7:0] mem [256];
    logic [7:0] w_a;
    assign w_a = mem_A[7:0];

    always_comb begin
        mem_RD = '0;
        case (mem_MemSrc[1:0])
            2'b00:   mem_RD = mem_MemSrc[2] ? {24'd0, mem[w_a]}
                                            : {{24{mem[w_a][7]}}, mem[w_a]};
            2'b01:   mem_RD = mem_MemSrc[2] ? {16'd0, mem[8'(w_a + 1)], mem[w_a]}
                                            : {{16{mem[8'(w_a + 1)][7]}}, mem[8'(w_a + 1)], mem[w_a]};
            default: mem_RD = {mem[8'(w_a + 3)], mem[8'(w_a + 2)], mem[8'(w_a + 1)], mem[w_a]};
        endcase
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h10] <= 8'hEF;
        mem[8'h11] <= 8'hBE;
        mem[8'h12] <= 8'hAD;
        mem[8'h13] <= 8'hDE;
    end

    always @(posedge clk) begin
        if (mem_WE) begin
            mem[w_a] <= mem_WD[7:0];
            if (mem_MemSrc[1:0] != 2'b00) mem[8'(w_a + 1)] <= mem_WD[15:8];
            if (mem_MemSrc[1:0] == 2'b10) begin
                mem[8'(w_a + 2)] <= mem_WD[23:16];
                mem[8'(w_a + 3)] <= mem_WD[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we, input logic [2:0] ms);
        if (p == 0) begin
            req0_valid = v; req0_addr = addr; req0_wdata = wd; req0_we = we; req0_memsrc = ms;
        end else begin
            req1_valid = v; req1_addr = addr; req1_wdata = wd; req1_we = we; req1_memsrc = ms;
        end
    endtask

    // One complete transaction; called just after a rising edge.
    task automatic txn(input string tag, input int p, input logic [31:0] addr,
                       input logic [31:0] wd, input logic we, input logic [2:0] ms,
                       input logic [31:0] exp_rd, input logic exp_err, output int nwait);
        logic rdy;
        logic active;
        active = !exp_err;
        nwait  = 0;
        drive(p, 1'b1, addr, wd, we, ms);
        #1;
        rdy = (p == 0) ? req0_ready : req1_ready;
        while (!rdy && nwait < 20) begin
            @(posedge clk); #1;
            nwait++;
            rdy = (p == 0) ? req0_ready : req1_ready;
        end
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        @(posedge clk); #1;
        drive(p, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        check({tag, "_access_we"}, 32'(mem_WE), 32'(we && active));
        check({tag, "_access_addr"}, mem_A, active ? addr : 32'd0);
        check({tag, "_access_norsp"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_rsp_valid"}, 32'(p == 0 ? rsp0_valid : rsp1_valid), 32'd1);
        check({tag, "_rsp_other"}, 32'(p == 0 ? rsp1_valid : rsp0_valid), 32'd0);
        check({tag, "_rsp_rdata"}, p == 0 ? rsp0_rdata : rsp1_rdata, exp_rd);
        check({tag, "_rsp_err"}, 32'(p == 0 ? rsp0_err : rsp1_err), 32'(exp_err));
        check({tag, "_resp_we"}, 32'(mem_WE), 32'd0);
        @(posedge clk); #1;
        check({tag, "_idle_rsp"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    endtask

    initial begin
        int nw;
        int exp_seq [6] = '{0, 0, 0, 0, 1, 0};
        logic got1;
        logic exp_err_mis;

        rst = 1'b1;
        drive(0, 1'b1, 32'h10, 32'd0, 1'b0, 3'b010);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready0", 32'(req0_ready), 32'd0);
        check("reset_mem_we", 32'(mem_WE), 32'd0);
        check("reset_mem_a", mem_A, 32'd0);
        check("reset_rsp0", 32'(rsp0_valid), 32'd0);
        check("reset_rdata0", rsp0_rdata, 32'd0);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        txn("core_load", 0, 32'h10, 32'd0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0, nw);
        check("core_load_wait", nw, 0);

        txn("ld_store", 1, 32'h20, 32'h12345678, 1'b1, 3'b010, 32'd0, 1'b0, nw);
        txn("ld_loadbu", 1, 32'h21, 32'd0, 1'b0, 3'b100, 32'h00000056, 1'b0, nw);
        txn("ld_loadh", 1, 32'h22, 32'd0, 1'b0, 3'b001, 32'h00001234, 1'b0, nw);
        txn("core_loadb_sx", 0, 32'h13, 32'd0, 1'b0, 3'b000, 32'hFFFFFFDE, 1'b0, nw);

        // Contested arbitration: four core grants, then the starved loader, then core.
        drive(0, 1'b1, 32'h10, 32'd0, 1'b0, 3'b010);
        drive(1, 1'b1, 32'h20, 32'd0, 1'b0, 3'b010);
        #1;
        for (int g = 0; g < 6; g++) begin
            nw = 0;
            while (!(req0_ready || req1_ready) && nw < 20) begin
                @(posedge clk); #1;
                nw++;
            end
            check($sformatf("prio_grant%0d_any", g), 32'(req0_ready | req1_ready), 32'd1);
            check($sformatf("prio_grant%0d_both", g), 32'(req0_ready & req1_ready), 32'd0);
            check($sformatf("prio_grant%0d_port1", g), 32'(req1_ready), 32'(exp_seq[g]));
            got1 = req1_ready;
            @(posedge clk); #1;
            if (got1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during ACCESS of a store aborts it.
        drive(0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, 3'b010);
        #1;
        check("rst_acc_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        rst = 1'b1;
        #1;
        check("rst_acc_we", 32'(mem_WE), 32'd0);
        check("rst_acc_addr", mem_A, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_after_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
        check("rst_after_we", 32'(mem_WE), 32'd0);
        check("rst_after_a", mem_A, 32'd0);
        @(posedge clk); #1;
        txn("rst_verify", 0, 32'h30, 32'd0, 1'b0, 3'b010, 32'd0, 1'b0, nw);
        check("rst_verify_wait", nw, 0);

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
        exp_err_mis = 1'b1;
`else
        exp_err_mis = 1'b0;
`endif
        txn("mis_store", 0, 32'h31, 32'hA5A5A5A5, 1'b1, 3'b010, 32'd0, exp_err_mis, nw);
        txn("mis_verify", 0, 32'h31, 32'd0, 1'b0, 3'b100,
            exp_err_mis ? 32'd0 : 32'h000000A5, 1'b0, nw);

        // Back-to-back: loader raised during RESP is accepted the next cycle.
        drive(0, 1'b1, 32'h10, 32'd0, 1'b0, 3'b010);
        #1;
        check("b2b_core_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h20, 32'd0, 1'b0, 3'b010);
        #1;
        check("b2b_resp_rsp0", 32'(rsp0_valid), 32'd1);
        check("b2b_resp_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check("b2b_idle_ready1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        check("b2b_access_addr", mem_A, 32'h20);
        @(posedge clk); #1;
        check("b2b_rsp1", 32'(rsp1_valid), 32'd1);
        check("b2b_rdata1", rsp1_rdata, 32'h12345678);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
